spectrum_bar_processor: RTL and testbench



---
 rtl/visuaudio_pkg.sv | 20 ++
 rtl/bin_level_encoder.sv | 31 +++
 rtl/spectrum_bar_processor.sv | 109 ++++++++++
 tb/tb_spectrum_bar_processor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/visuaudio_pkg.sv
// Shared types and constants for the audio visualiser datapath
// (FFT controller -> bar processor -> display renderer).
package visuaudio_pkg;

    localparam int NUM_BINS = 16;
    localparam int BIN_W    = 16;
    localparam int LEVEL_W  = 4;
    localparam int IDX_W    = $clog2(NUM_BINS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_PROC,
        S_DONE
    } state_t;

    typedef logic [NUM_BINS-1:0][BIN_W-1:0]   bin_arr_t;
    typedef logic [NUM_BINS-1:0][LEVEL_W-1:0] level_arr_t;

endpackage

// File: rtl/bin_level_encoder.sv
// Signed spectrum bin to log-scale bar level: |bin| (most negative value
// saturated), then leading-one position + 1, or 0 for a zero bin.
module bin_level_encoder
    import visuaudio_pkg::*;
(
    input  logic [BIN_W-1:0]   bin,
    output logic [LEVEL_W-1:0] level
);

    logic [BIN_W-2:0] mag;

    always_comb begin
        if (bin[BIN_W-1]) begin
            mag = ~bin[BIN_W-2:0] + 1'b1;
            // the most negative code has no positive twin; clamp to full scale
            if (bin[BIN_W-2:0] == '0) begin
                mag = '1;
            end
        end else begin
            mag = bin[BIN_W-2:0];
        end

        level = '0;
        for (int i = 0; i < BIN_W-1; i++) begin
            if (mag[i]) begin
                level = LEVEL_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/spectrum_bar_processor.sv
// Per-frame bar levels and decaying peak-hold markers for the spectrum display.
//   state   | meaning
//   S_IDLE  | waiting for a frame-done pulse from the FFT controller
//   S_LATCH | snapshot of the input bins taken at the end of this cycle
//   S_PROC  | one bin per cycle, k = 0..NUM_BINS-1, level into shadow array
//   S_DONE  | o_frame_valid pulse, new o_level visible
module spectrum_bar_processor
    import visuaudio_pkg::*;
#(
    parameter int DECAY_PERIOD = 3000000
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_BINS-1:0][BIN_W-1:0]   i_data,
    input  logic                             i_data_done,
    output logic [NUM_BINS-1:0][LEVEL_W-1:0] o_level,
    output logic [NUM_BINS-1:0][LEVEL_W-1:0] o_peak,
    output logic                             o_frame_valid,
    output logic                             o_busy,
    output logic                             o_overrun
);

    localparam int               CNT_W    = $clog2(DECAY_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_PERIOD - 1);
    localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(NUM_BINS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   k_q;
    bin_arr_t           snap_q;
    level_arr_t         shadow_q, shadow_d, peak_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               tick, proc, last_bin;
    logic [LEVEL_W-1:0] level_k, decayed;

    assign tick          = (cnt_q == CNT_LAST);
    assign proc          = (state_q == S_PROC);
    assign last_bin      = proc && (k_q == K_LAST);
    assign o_busy        = (state_q != S_IDLE);
    assign o_frame_valid = (state_q == S_DONE);

    bin_level_encoder u_enc (
        .bin   (snap_q[k_q]),
        .level (level_k)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_data_done) state_d = S_LATCH;
            S_LATCH: state_d = S_PROC;
            S_PROC:  if (k_q == K_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Decay and the fresh level meet in one max, so a tick never hides a new peak.
    always_comb begin
        shadow_d = shadow_q;
        peak_d   = o_peak;
        decayed  = '0;
        if (proc) begin
            shadow_d[k_q] = level_k;
        end
        for (int j = 0; j < NUM_BINS; j++) begin
            decayed = (tick && (o_peak[j] != '0)) ? o_peak[j] - 1'b1 : o_peak[j];
            if (proc && (k_q == IDX_W'(j)) && (level_k > decayed)) begin
                peak_d[j] = level_k;
            end else begin
                peak_d[j] = decayed;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            k_q       <= '0;
            snap_q    <= '0;
            shadow_q  <= '0;
            o_level   <= '0;
            o_peak    <= '0;
            o_overrun <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (state_q == S_LATCH) begin
                snap_q <= i_data;
            end
            k_q      <= proc ? k_q + 1'b1 : '0;
            shadow_q <= shadow_d;
            if (last_bin) begin
                o_level <= shadow_d;
            end
            o_peak <= peak_d;
            if (i_data_done && (state_q != S_IDLE)) begin
                o_overrun <= 1'b1;
            end
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_spectrum_bar_processor.sv
// Directed bench: one slow-decay and one fast-decay instance share stimulus.
module tb_spectrum_bar_processor;
    import visuaudio_pkg::*;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       done = 1'b0;
    bin_arr_t   data = '0;
    level_arr_t lvl_s, pk_s, lvl_f, pk_f;
    logic       fv_s, busy_s, ov_s, fv_f, busy_f, ov_f;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    bit trace_en  = 1'b0;
    int trace_err = 0;

    level_arr_t pkf_hist [0:19];
    level_arr_t lvl_s_done, lvl_f_done, pk_s_done;

    typedef struct {
        logic [BIN_W-1:0]   bin;
        logic [LEVEL_W-1:0] lvl;
    } vec_t;
    vec_t vecs [32];

    always #5 clk = ~clk;

    spectrum_bar_processor #(.DECAY_PERIOD(1000)) dut_slow (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_data_done(done),
        .o_level(lvl_s), .o_peak(pk_s), .o_frame_valid(fv_s),
        .o_busy(busy_s), .o_overrun(ov_s)
    );

    spectrum_bar_processor #(.DECAY_PERIOD(8)) dut_fast (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_data_done(done),
        .o_level(lvl_f), .o_peak(pk_f), .o_frame_valid(fv_f),
        .o_busy(busy_f), .o_overrun(ov_f)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // cycle 0 is the first cycle after reset release; fast decay ticks in cycles 7, 15, 23, ...
    task automatic step();
        int e;
        @(posedge clk);
        #2;
        cyc++;
        if (trace_en && cyc >= 8 && cyc <= 150) begin
            e = 15 - (cyc - 8) / 8;
            if (e < 0) e = 0;
            if (pk_f[0] != 4'(e)) trace_err++;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic full_reset();
        rst  = 1'b1;
        done = 1'b0;
        data = '0;
        #1;
        release_reset();
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step();
    endtask

    // Pulse in the current cycle T, run to T+19; optional extra pulses at T+x1, T+x2.
    task automatic run_frame(input bin_arr_t d, input int x1, input int x2, input string tag);
        logic [19:0] vm_s, bm_s, vm_f, bm_f;
        data = d;
        done = 1'b1;
        vm_s = '0; bm_s = '0; vm_f = '0; bm_f = '0;
        vm_s[0] = fv_s; bm_s[0] = busy_s; vm_f[0] = fv_f; bm_f[0] = busy_f;
        pkf_hist[0] = pk_f;
        for (int i = 1; i < 20; i++) begin
            step();
            done = (i == x1) || (i == x2);
            vm_s[i] = fv_s; bm_s[i] = busy_s;
            vm_f[i] = fv_f; bm_f[i] = busy_f;
            pkf_hist[i] = pk_f;
            if (i == 18) begin
                lvl_s_done = lvl_s;
                lvl_f_done = lvl_f;
                pk_s_done  = pk_s;
            end
        end
        done = 1'b0;
        chk($sformatf("%s valid_slow", tag), 64'(vm_s), 64'h40000);
        chk($sformatf("%s valid_fast", tag), 64'(vm_f), 64'h40000);
        chk($sformatf("%s busy_slow", tag), 64'(bm_s), 64'h7FFFE);
        chk($sformatf("%s busy_fast", tag), 64'(bm_f), 64'h7FFFE);
    endtask

    // Frame A (T=10, all bins level 12) then frame B (T=34) so bin 3 lands in tick cycle 39.
    task automatic collision(input logic [BIN_W-1:0] b3, input logic [LEVEL_W-1:0] exp3,
                             input string tag);
        bin_arr_t   d;
        level_arr_t e39, e40;
        full_reset();
        step_to(10);
        d = {NUM_BINS{16'h0800}};
        run_frame(d, 0, 0, $sformatf("%s frameA", tag));
        step_to(34);
        d = '0;
        d[3] = b3;
        run_frame(d, 0, 0, $sformatf("%s frameB", tag));
        for (int j = 0; j < NUM_BINS; j++) begin
            e39[j] = (j < 3) ? 4'd9 : (j <= 10) ? 4'd10 : 4'd11;
            e40[j] = (j == 3) ? exp3 : e39[j] - 4'd1;
        end
        chk($sformatf("%s peaks before tick", tag), pkf_hist[5], e39);
        chk($sformatf("%s peak3 after", tag), 64'(pkf_hist[6][3]), 64'(exp3));
        chk($sformatf("%s peaks after", tag), pkf_hist[6], e40);
    endtask

    initial begin
        bin_arr_t   d;
        level_arr_t exp_lvl;

        vecs[0]  = '{16'h0000, 4'd0};  vecs[1]  = '{16'h0001, 4'd1};
        vecs[2]  = '{16'hFFFF, 4'd1};  vecs[3]  = '{16'h7FFF, 4'd15};
        vecs[4]  = '{16'h8000, 4'd15}; vecs[5]  = '{16'h0100, 4'd9};
        vecs[6]  = '{16'h0003, 4'd2};
        for (int j = 7; j < 16; j++) vecs[j] = '{16'h0000, 4'd0};
        vecs[16] = '{16'h0002, 4'd2};  vecs[17] = '{16'h0004, 4'd3};
        vecs[18] = '{16'hFFFE, 4'd2};  vecs[19] = '{16'h8001, 4'd15};
        vecs[20] = '{16'h4000, 4'd15}; vecs[21] = '{16'h3FFF, 4'd14};
        vecs[22] = '{16'hC000, 4'd15}; vecs[23] = '{16'hFF00, 4'd9};
        vecs[24] = '{16'h00FF, 4'd8};  vecs[25] = '{16'h0080, 4'd8};
        vecs[26] = '{16'h007F, 4'd7};  vecs[27] = '{16'hFFF9, 4'd3};
        vecs[28] = '{16'h0010, 4'd5};  vecs[29] = '{16'h0400, 4'd11};
        vecs[30] = '{16'h1000, 4'd13}; vecs[31] = '{16'hF000, 4'd13};

        // reset state
        full_reset();
        chk("reset level/peak slow", {lvl_s, pk_s} == '0, 1'b1);
        chk("reset flags", 64'({fv_s, busy_s, ov_s, fv_f, busy_f, ov_f}), 64'h0);

        // level mapping table, two frames of 16 bins
        for (int f = 0; f < 2; f++) begin
            full_reset();
            step_to(3);
            for (int j = 0; j < NUM_BINS; j++) begin
                d[j]       = vecs[f*16 + j].bin;
                exp_lvl[j] = vecs[f*16 + j].lvl;
            end
            run_frame(d, 0, 0, $sformatf("map%0d", f));
            for (int j = 0; j < NUM_BINS; j++) begin
                chk($sformatf("map%0d level[%0d]", f, j), 64'(lvl_s_done[j]), 64'(vecs[f*16 + j].lvl));
                chk($sformatf("map%0d peak[%0d]", f, j), 64'(pk_s_done[j]), 64'(vecs[f*16 + j].lvl));
            end
            chk($sformatf("map%0d level hold", f), lvl_s, exp_lvl);
            chk($sformatf("map%0d overrun", f), 64'(ov_s), 64'h0);
        end

        // peak decay on the fast instance
        full_reset();
        step_to(5);
        trace_en = 1'b1;
        d = '0;
        d[0] = 16'h7FFF;
        run_frame(d, 0, 0, "decay f1");
        chk("decay peak0 at T+3", 64'(pkf_hist[3][0]), 64'd15);
        chk("decay level0 f1", 64'(lvl_f_done[0]), 64'd15);
        run_frame('0, 0, 0, "decay f2");
        chk("decay level0 f2", 64'(lvl_f_done[0]), 64'd0);
        step_to(150);
        trace_en = 1'b0;
        chk("decay trace errors", 64'(trace_err), 64'd0);
        chk("decay final peak0", 64'(pk_f[0]), 64'd0);

        // tick/update collision
        collision(16'h0100, 4'd9, "coll9");
        collision(16'h0800, 4'd12, "coll12");

        // overrun
        full_reset();
        step_to(2);
        d = {NUM_BINS{16'h0003}};
        run_frame(d, 5, 18, "ovr");
        chk("ovr sticky slow", 64'(ov_s), 64'h1);
        chk("ovr sticky fast", 64'(ov_f), 64'h1);
        chk("ovr level", lvl_s_done, {NUM_BINS{4'd2}});
        d = {NUM_BINS{16'h0010}};
        run_frame(d, 0, 0, "after ovr");
        chk("after ovr level", lvl_s_done, {NUM_BINS{4'd5}});
        chk("ovr still set", 64'(ov_s), 64'h1);

        // back-to-back frames
        full_reset();
        step_to(2);
        run_frame({NUM_BINS{16'h0003}}, 0, 0, "b2b f1");
        chk("b2b f1 level", lvl_s_done, {NUM_BINS{4'd2}});
        run_frame({NUM_BINS{16'h0010}}, 0, 0, "b2b f2");
        chk("b2b f2 level", lvl_s_done, {NUM_BINS{4'd5}});
        chk("b2b overrun", 64'({ov_s, ov_f}), 64'h0);

        // asynchronous reset mid-frame
        full_reset();
        step_to(2);
        run_frame({NUM_BINS{16'h7FFF}}, 0, 0, "mid f1");
        data = {NUM_BINS{16'h0003}};
        done = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            done = (i == 5);
        end
        done = 1'b0;
        chk("mid busy before reset", 64'(busy_s), 64'h1);
        chk("mid overrun before reset", 64'(ov_s), 64'h1);
        rst = 1'b1;
        #1;
        chk("mid reset level slow", lvl_s, '0);
        chk("mid reset peak slow", pk_s, '0);
        chk("mid reset level fast", lvl_f, '0);
        chk("mid reset peak fast", pk_f, '0);
        chk("mid reset flags", 64'({fv_s, busy_s, ov_s, fv_f, busy_f, ov_f}), 64'h0);
        release_reset();
        step_to(2);
        run_frame({NUM_BINS{16'h0100}}, 0, 0, "mid f2");
        chk("mid f2 level", lvl_s_done, {NUM_BINS{4'd9}});
        chk("mid f2 peak", pk_s_done, {NUM_BINS{4'd9}});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
